// File: rtl/bin2bcd_seq_if.sv
// Handshake and digit bus between a binary source and bin2bcd_seq.
// master: source side (drives start/bin_in); slave: the converter.
interface bin2bcd_seq_if #(
    parameter int IN_W = 14
);
    logic            start;
    logic [IN_W-1:0] bin_in;
    logic            busy;
    logic            valid;
    logic            ovf;
    logic [3:0]      d3;
    logic [3:0]      d2;
    logic [3:0]      d1;
    logic [3:0]      d0;

    modport master (
        output start, bin_in,
        input  busy, valid, ovf, d3, d2, d1, d0
    );

    modport slave (
        input  start, bin_in,
        output busy, valid, ovf, d3, d2, d1, d0
    );
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter feeding a 4-digit display mux.
// Optional macro BIN2BCD_LEADING_ZERO_BLANK_EN blanks leading zero digits as 4'hF.
//
// state | meaning
// IDLE  | waiting for start; digits/ovf hold the last result
// CONV  | one add-3/shift iteration per cycle, IN_W iterations
// DONE  | one cycle; digits, ovf and valid update on the exiting edge
module bin2bcd_seq #(
    parameter int IN_W    = 14,
    parameter int MAX_VAL = 9999
) (
    input  logic          clk,
    input  logic          rst,
    bin2bcd_seq_if.slave  bus
);
    localparam int CNT_W = $clog2(IN_W + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CONV = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [31:0] MAX_W = MAX_VAL;

`ifdef BIN2BCD_LEADING_ZERO_BLANK_EN
    localparam logic [3:0] LEAD_RST = 4'hF;
`else
    localparam logic [3:0] LEAD_RST = 4'h0;
`endif

    logic [1:0]       state_q, state_d;
    logic [IN_W-1:0]  shift_q, shift_d;
    logic [15:0]      acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sat_q, sat_d;
    logic             busy_q, busy_d;
    logic             valid_q, valid_d;
    logic             ovf_q, ovf_d;
    logic [3:0]       d3_q, d3_d;
    logic [3:0]       d2_q, d2_d;
    logic [3:0]       d1_q, d1_d;
    logic [3:0]       d0_q, d0_d;

    logic [15:0]      acc_corr;
    logic             in_sat;
    logic             blank3, blank2, blank1;
    logic [3:0]       out3, out2, out1, out0;

    function automatic logic [3:0] add3(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

    assign acc_corr = {add3(acc_q[15:12]), add3(acc_q[11:8]),
                       add3(acc_q[7:4]),   add3(acc_q[3:0])};

    assign in_sat = ({{(32-IN_W){1'b0}}, bus.bin_in} > MAX_W);

`ifdef BIN2BCD_LEADING_ZERO_BLANK_EN
    assign blank3 = ~sat_q && (acc_q[15:12] == 4'd0);
    assign blank2 = blank3 && (acc_q[11:8] == 4'd0);
    assign blank1 = blank2 && (acc_q[7:4] == 4'd0);
`else
    assign blank3 = 1'b0;
    assign blank2 = 1'b0;
    assign blank1 = 1'b0;
`endif

    // Saturation wins over blanking so an overflow always reads 9999.
    assign out3 = sat_q ? 4'd9 : (blank3 ? 4'hF : acc_q[15:12]);
    assign out2 = sat_q ? 4'd9 : (blank2 ? 4'hF : acc_q[11:8]);
    assign out1 = sat_q ? 4'd9 : (blank1 ? 4'hF : acc_q[7:4]);
    assign out0 = sat_q ? 4'd9 : acc_q[3:0];

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        sat_d   = sat_q;
        busy_d  = busy_q;
        valid_d = 1'b0;
        ovf_d   = ovf_q;
        d3_d    = d3_q;
        d2_d    = d2_q;
        d1_d    = d1_q;
        d0_d    = d0_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = CONV;
                    shift_d = bus.bin_in;
                    acc_d   = 16'd0;
                    cnt_d   = CNT_W'(IN_W);
                    sat_d   = in_sat;
                    busy_d  = 1'b1;
                end
            end
            CONV: begin
                {acc_d, shift_d} = {acc_corr, shift_q} << 1;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                valid_d = 1'b1;
                ovf_d   = sat_q;
                d3_d    = out3;
                d2_d    = out2;
                d1_d    = out1;
                d0_d    = out0;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            shift_q <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            d3_q    <= LEAD_RST;
            d2_q    <= LEAD_RST;
            d1_q    <= LEAD_RST;
            d0_q    <= 4'd0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            sat_q   <= sat_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
            d3_q    <= d3_d;
            d2_q    <= d2_d;
            d1_q    <= d1_d;
            d0_q    <= d0_d;
        end
    end

    assign bus.busy  = busy_q;
    assign bus.valid = valid_q;
    assign bus.ovf   = ovf_q;
    assign bus.d3    = d3_q;
    assign bus.d2    = d2_q;
    assign bus.d1    = d1_q;
    assign bus.d0    = d0_q;
endmodule

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
- Sequential binary-to-BCD converter that sits directly upstream of the 4-digit seven-segment multiplexer.
- Converts an unsigned binary value (e.g. a UART-received count or byte) into four BCD digits d3..d0, which drive the multiplexer's digit inputs.
- Uses shift-and-add-3 (double dabble), one bit per clock.
- Digit outputs are registered and change atomically, so the display never shows a partial result.

Parameters:
- IN_W, 14, width of the binary input; legal range 4..16.
- MAX_VAL, 9999, largest displayable value; larger inputs saturate.

Ports:
- CLK  input  1  system clock; all state changes on the rising edge.
- RST  input  1  reset, asynchronous, active-high.
- start  input  1  request; samples bin_in when the block is idle.
- bin_in  input  IN_W  unsigned binary value to convert.
- busy  output  1  high while a conversion is in progress.
- valid  output  1  one-cycle pulse when new digits are presented.
- ovf  output  1  registered; high if the last converted value exceeded MAX_VAL.
- d3  output  4  thousands digit (BCD).
- d2  output  4  hundreds digit.
- d1  output  4  tens digit.
- d0  output  4  units digit.

Behaviour:
- Reset (async, RST=1):
  - state=IDLE, busy=0, valid=0, ovf=0, d3..d0=0.
  - Internal shift register and bit counter are cleared.
- FSM states and transitions:
  - IDLE -> CONV: on start=1. Latch bin_in into the shift register, clear the 16-bit BCD accumulator, load counter=IN_W, busy=1. Also latch sat = (bin_in > MAX_VAL), compared at full IN_W width.
  - CONV: each cycle, add 3 to every accumulator nibble >= 5, then shift {accumulator, shift register} left by one and decrement the counter. When the counter reaches 1, the transition is CONV -> DONE at the next edge.
  - DONE -> IDLE: after exactly one cycle. On this edge, d3..d0 load the accumulator nibbles (or 9,9,9,9 if sat=1), ovf loads sat, valid=1 for this single cycle, busy=0.
- Latency:
  - start is sampled at edge N.
  - Outputs update and valid rises at edge N+IN_W+1.
  - busy is high over edges N..N+IN_W.
  - Latency is constant regardless of value or saturation.
- start while busy=1 is ignored; the in-flight conversion completes with its latched value.
- start asserted in the same cycle that valid pulses is accepted, since the FSM is IDLE after the DONE edge only. Define: start is sampled only in IDLE, so back-to-back throughput is one conversion per IN_W+2 cycles.
- bin_in may change freely after the sampling edge.
- d3..d0 and ovf hold their values between conversions. Only the DONE edge or reset modifies them.
- Reset mid-conversion: immediate abort. Outputs return to reset values, no valid pulse, FSM returns to IDLE.
- Arithmetic:
  - Accumulator is 16 bits (4 nibbles). The add-3 correction is applied per nibble before each shift, including on the first iteration (a no-op then).
  - Widths above 14 bits rely on saturation; nibble 3 overflow is never observable because sat forces 9999.

Optional Feature:
- Macro: BIN2BCD_LEADING_ZERO_BLANK_EN.
- Defined:
  - At the DONE edge, leading-zero digits are replaced by 4'hF, which the downstream decoder renders as blank. Scanning runs d3, then d2, then d1; blanking stops at the first nonzero digit.
  - d0 is never blanked.
  - Reset values become d3=d2=d1=4'hF, d0=0.
  - Saturated output 9999 is never blanked.
- Undefined: digits are always plain BCD 0..9; reset values are all 0.

Test Plan:
- Reset then idle -> busy=0, valid=0, ovf=0, d3..d0=0,0,0,0 (with BIN2BCD_LEADING_ZERO_BLANK_EN: F,F,F,0).
- start=1 with bin_in=1234, IN_W=14 -> valid pulse exactly 15 edges after the sampling edge; d3..d0=1,2,3,4; ovf=0; busy high for 15 edges before that.
- bin_in=0, then 9999, then 7 back-to-back, start held high -> three results 0000, 9999, 0007 each spaced 16 cycles apart. With blanking, 7 gives F,F,F,7 and 0 gives F,F,F,0.
- bin_in=12000 -> d3..d0=9,9,9,9, ovf=1, same latency. Following conversion of 42 -> ovf returns to 0, digits 0,0,4,2.
- Convert 5678, then pulse start with bin_in=1111 at edge N+5 -> second start ignored; result 5,6,7,8; no second valid.
- Assert RST at edge N+7 of a conversion -> outputs immediately at reset values, no valid pulse. A fresh start after release converts correctly.
